// File: rtl/multiples_pkg.sv
// Shared constants and state encoding for the multiples FIFO controller, the
// array wrapper and the producer/consumer blocks.
package multiples_pkg;

  localparam int DEPTH  = 10;
  localparam int ADDR_W = 13;
  localparam int CNT_W  = 4;
  localparam int PTR_W  = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Wrapping increment: DEPTH is not a power of two, so compare-and-clear.
  function automatic logic [PTR_W-1:0] ptr_wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/multiples_fifo_ctrl_if.sv
// Handshake and array-control bundle between the producer/consumer side
// (master) and the FIFO controller (slave).
interface multiples_fifo_ctrl_if;
  import multiples_pkg::*;

  logic              push_valid;
  logic              push_ready;
  logic              pop_valid;
  logic              pop_ready;
  logic              flush;
  logic              fifo_write_enable;
  logic [ADDR_W-1:0] fifo_write_address;
  logic [ADDR_W-1:0] fifo_read_address;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output push_valid, pop_ready, flush,
    input  push_ready, pop_valid, fifo_write_enable, fifo_write_address,
           fifo_read_address, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push_valid, pop_ready, flush,
    output push_ready, pop_valid, fifo_write_enable, fifo_write_address,
           fifo_read_address, count, full, empty, overflow, underflow
  );

endinterface

// File: rtl/multiples_fifo_ctrl_ptr_inc.sv
// Wrapping pointer incrementer (0..DEPTH-1), used for both FIFO pointers.
module multiples_fifo_ctrl_ptr_inc
  import multiples_pkg::*;
(
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] inc_o
);

  assign inc_o = ptr_wrap_inc(ptr_i);

endmodule

// File: rtl/multiples_fifo_ctrl.sv
// Pointer/handshake controller for the 10-entry multiples_fifo array: turns
// push/pop valid-ready into raw array strobes and tracks occupancy and errors.
module multiples_fifo_ctrl
  import multiples_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  multiples_fifo_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_inc_s, rd_inc_s;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             full_s, empty_s, run_s, take_s;
  logic             push_ready_s, pop_valid_s, push_fire_s, pop_fire_s;

  multiples_fifo_ctrl_ptr_inc u_wr_inc (.ptr_i(wr_ptr_q), .inc_o(wr_inc_s));
  multiples_fifo_ctrl_ptr_inc u_rd_inc (.ptr_i(rd_ptr_q), .inc_o(rd_inc_s));

  assign full_s       = (count_q == CNT_W'(DEPTH));
  assign empty_s      = (count_q == {CNT_W{1'b0}});
  assign run_s        = (state_q == RUN);
  assign push_ready_s = !full_s && run_s;
  assign pop_valid_s  = !empty_s && run_s;
  // The flush cycle swallows both handshakes; reset kills an in-flight write.
  assign take_s       = !bus.flush && !reset;
  assign push_fire_s  = bus.push_valid && push_ready_s && take_s;
  assign pop_fire_s   = bus.pop_ready && pop_valid_s && take_s;

  assign bus.push_ready         = push_ready_s;
  assign bus.pop_valid          = pop_valid_s;
  assign bus.fifo_write_enable  = push_fire_s;
  assign bus.fifo_write_address = ADDR_W'(wr_inc_s);
  assign bus.fifo_read_address  = ADDR_W'(rd_ptr_q);
  assign bus.count              = count_q;
  assign bus.full               = full_s;
  assign bus.empty              = empty_s;
  assign bus.overflow           = overflow_q;
  assign bus.underflow          = underflow_q;

  // Next-state: pointer/count update in RUN; flush clears on entry to FLUSH.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    case (state_q)
      RUN: begin
        if (bus.flush) begin
          state_d  = FLUSH;
          wr_ptr_d = {PTR_W{1'b0}};
          rd_ptr_d = {PTR_W{1'b0}};
          count_d  = {CNT_W{1'b0}};
        end else begin
          if (push_fire_s) wr_ptr_d = wr_inc_s;
          else             wr_ptr_d = wr_ptr_q;
          if (pop_fire_s)  rd_ptr_d = rd_inc_s;
          else             rd_ptr_d = rd_ptr_q;
          case ({push_fire_s, pop_fire_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
          endcase
          overflow_d  = overflow_q  || (bus.push_valid && full_s);
          underflow_d = underflow_q || (bus.pop_ready && empty_s);
        end
      end
      FLUSH: begin
        state_d  = RUN;
        wr_ptr_d = {PTR_W{1'b0}};
        rd_ptr_d = {PTR_W{1'b0}};
        count_d  = {CNT_W{1'b0}};
      end
      default: state_d = RUN;
    endcase
  end

  // State, pointer, occupancy and sticky-error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_multiples_fifo_ctrl.sv
// Directed bench for multiples_fifo_ctrl with a behavioural array and a data
// scoreboard; controller expectations come from a small reference model.
module tb_multiples_fifo_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] mem [0:9];

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] sb [$];
  int m_wr, m_rd, m_cnt;
  bit m_flush_st, m_ovf, m_unf;

  multiples_fifo_ctrl_if bus ();

  multiples_fifo_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural storage array: address a lands in slot (a-1) mod 10.
  always @(posedge clk) begin
    if (bus.fifo_write_enable) begin
      if (bus.fifo_write_address == 13'd0) mem[9] <= wdata;
      else mem[bus.fifo_write_address - 13'd1] <= wdata;
    end
  end

  always_comb rdata = mem[bus.fifo_read_address[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("count", 32'(bus.count), 32'(m_cnt));
    chk("full", 32'(bus.full), 32'(m_cnt == 10));
    chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
  endtask

  // One clock: drive inputs, check combinational outputs, clock, check state.
  task automatic cycle(input logic pv, input logic [7:0] d, input logic pr, input logic fl);
    bit run, e_pr, e_pv, pf, qf;
    logic [7:0] exp_d;
    bus.push_valid = pv;
    wdata          = d;
    bus.pop_ready  = pr;
    bus.flush      = fl;
    #1;
    run  = !m_flush_st;
    e_pr = run && (m_cnt < 10);
    e_pv = run && (m_cnt > 0);
    pf   = pv && e_pr && !fl;
    qf   = pr && e_pv && !fl;
    chk("push_ready", 32'(bus.push_ready), 32'(e_pr));
    chk("pop_valid", 32'(bus.pop_valid), 32'(e_pv));
    chk("write_enable", 32'(bus.fifo_write_enable), 32'(pf));
    chk("write_address", 32'(bus.fifo_write_address), 32'((m_wr == 9) ? 0 : m_wr + 1));
    chk("read_address", 32'(bus.fifo_read_address), 32'(m_rd));
    if (pf) sb.push_back(d);
    if (qf) begin
      if (sb.size() == 0) exp_d = 8'hxx;
      else exp_d = sb.pop_front();
      chk("pop_data", 32'(rdata), 32'(exp_d));
    end
    if (run && !fl) begin
      if (pv && m_cnt == 10) m_ovf = 1'b1;
      if (pr && m_cnt == 0)  m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!run) begin
      m_flush_st = 1'b0;
    end else if (fl) begin
      m_wr = 0; m_rd = 0; m_cnt = 0; m_flush_st = 1'b1;
      sb.delete();
    end else begin
      if (pf) m_wr = (m_wr == 9) ? 0 : m_wr + 1;
      if (qf) m_rd = (m_rd == 9) ? 0 : m_rd + 1;
      m_cnt = m_cnt + int'(pf) - int'(qf);
    end
    chk_state();
  endtask

  initial begin
    m_wr = 0; m_rd = 0; m_cnt = 0; m_flush_st = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    reset = 1'b1;
    bus.push_valid = 1'b1;
    bus.pop_ready  = 1'b1;
    bus.flush      = 1'b0;
    wdata          = 8'h00;
    #3;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_push_ready", 32'(bus.push_ready), 32'd1);
    chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("rst_write_enable", 32'(bus.fifo_write_enable), 32'd0);
    bus.push_valid = 1'b0;
    bus.pop_ready  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_state();

    // Underflow on pop while empty; read pointer must not move.
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_sticky", 32'(bus.underflow), 32'd1);
    chk("unf_rd_ptr", 32'(bus.fifo_read_address), 32'd0);

    // Three back-to-back pushes, then drain in order.
    cycle(1'b1, 8'h0A, 1'b0, 1'b0);
    cycle(1'b1, 8'h0B, 1'b0, 1'b0);
    cycle(1'b1, 8'h0C, 1'b0, 1'b0);
    chk("three_count", 32'(bus.count), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("three_empty", 32'(bus.empty), 32'd1);

    // Fill to full, attempt an 11th push, then drain all ten.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_push_ready", 32'(bus.push_ready), 32'd0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    // Full with a pop: push still refused.
    cycle(1'b1, 8'hEF, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Hold at five with simultaneous push/pop across two pointer wraps.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
    chk("steady_count", 32'(bus.count), 32'd5);

    // Empty with push and pop together: only the push fires.
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to seven, flush with push/pop requests present.
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_rd_ptr", 32'(bus.fifo_read_address), 32'd0);
    chk("flush_wr_addr", 32'(bus.fifo_write_address), 32'd1);
    cycle(1'b1, 8'h98, 1'b1, 1'b1);
    cycle(1'b1, 8'h91, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-burst at count four with a push in flight.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    bus.push_valid = 1'b1;
    wdata          = 8'hAB;
    #1;
    chk("burst_we", 32'(bus.fifo_write_enable), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(bus.fifo_write_enable), 32'd0);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_push_ready", 32'(bus.push_ready), 32'd1);
    chk("mid_rst_rd_ptr", 32'(bus.fifo_read_address), 32'd0);
    chk("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    bus.push_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_wr = 0; m_rd = 0; m_cnt = 0; m_flush_st = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    sb.delete();
    #1;
    chk_state();
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
